// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and op-class helpers for muldiv_unit
package muldiv_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } md_state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return op inside {MD_MSUB, MD_MSUBU};
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - unsigned restoring divider core, one quotient bit per cycle
module muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;

    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        last      = active_q && (cnt_q == CW'(1));
        if (abort) begin
            active_d = 1'b0;
        end else if (start) begin
            rem_d    = '0;
            quo_d    = dividend;
            dvs_d    = divisor;
            cnt_d    = CW'(WIDTH);
            active_d = 1'b1;
        end else if (active_q) begin
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = rem_diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (last) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with accumulate ops and flush undo window
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    md_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             undo_q, undo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] old_hi_q, old_hi_d, old_lo_q, old_lo_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

    logic             accept, undo_hit;
    logic             div_start, div_last;
    logic [WIDTH-1:0] mag_a, mag_b, div_quo, div_rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mul_res;

    muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (undo_hit),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        accept    = start & ~busy_q & ~flush & (op <= MD_MSUBU);
        undo_hit  = flush & undo_q;
        div_start = accept & is_div(op);
        // The most-negative value negates to itself, which reads correctly as an unsigned magnitude.
        mag_a = (is_signed(op) & src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b = (is_signed(op) & src_b[WIDTH-1]) ? -src_b : src_b;

        ext_a   = is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = ext_a * ext_b;
        acc     = {old_hi_q, old_lo_q};
        mul_res = is_sub(op_q) ? (acc - prod) : (is_acc(op_q) ? (acc + prod) : prod);

        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        undo_d   = undo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        old_hi_d = old_hi_q;
        old_lo_d = old_lo_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;

        if (undo_hit) begin
            hi_d    = old_hi_q;
            lo_d    = old_lo_q;
            busy_d  = 1'b0;
            state_d = IDLE;
            undo_d  = 1'b0;
        end else if (accept) begin
            old_hi_d = hi_q;
            old_lo_d = lo_q;
            undo_d   = 1'b1;
            op_d     = op;
            a_d      = src_a;
            b_d      = src_b;
            q_neg_d  = is_signed(op) & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_d  = is_signed(op) & src_a[WIDTH-1];
            dz_d     = (src_b == '0);
            if (op == MD_MTHI) begin
                hi_d = src_a;
            end else if (op == MD_MTLO) begin
                lo_d = src_a;
            end else if (is_mul(op)) begin
                state_d = MUL;
                cnt_d   = MUL_CNT_INIT;
                busy_d  = 1'b1;
            end else begin
                state_d = DIV_ITER;
                busy_d  = 1'b1;
            end
        end else begin
            case (state_q)
                // Idle covers both the MTHI/MTLO follow-up cycle and the done cycle: the window closes here.
                IDLE: undo_d = 1'b0;
                MUL: begin
                    if (cnt_q == 4'd0) begin
                        {hi_d, lo_d} = mul_res;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DIV_ITER: begin
                    if (div_last) begin
                        state_d = DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (dz_q) begin
                        hi_d = '0;
                        lo_d = '0;
                    end else begin
                        lo_d = q_neg_q ? -div_quo : div_quo;
                        hi_d = r_neg_q ? -div_rem : div_rem;
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            undo_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            old_hi_q <= '0;
            old_lo_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            undo_q   <= undo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            old_hi_q <= old_hi_d;
            old_lo_q <= old_lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - table-driven and sequence checks for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, ihi, ilo, ehi, elo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        issue(MD_MTHI, h, 32'd0);
        issue(MD_MTLO, l, 32'd0);
    endtask

    // Counts busy cycles starting just after the accept edge; returns right after the completion edge.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int dc;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{MD_DIVU,  32'd100,      32'd7,        32'd0,        32'd0,        32'd2,        32'd14,       33};
        vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4]  = '{MD_DIV,   32'd7,        32'd0,        32'd5,        32'd6,        32'd0,        32'd0,        33};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        32'h80000000, 33};
        vecs[6]  = '{MD_MADDU, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        5};
        vecs[7]  = '{MD_MSUB,  32'd2,        32'd3,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[8]  = '{MD_MADD,  32'hFFFFFFFE, 32'd3,        32'd0,        32'd10,       32'd0,        32'd4,        5};
        vecs[9]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        32'd1,        32'hFFFFFFFD, 33};
        vecs[10] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 33};
        vecs[11] = '{MD_MSUBU, 32'd1,        32'd1,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            set_hilo(vecs[i].ihi, vecs[i].ilo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            dc = done_cnt;
            wait_idle(n);
            check($sformatf("v%0d_latency", i), n, vecs[i].lat);
            check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].elo);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulses", i), done_cnt - dc, 32'd1);
        end

        // MTHI undone by a flush in the following cycle
        set_hilo(32'h11, 32'h22);
        issue(MD_MTHI, 32'hAA, 32'd0);
        check("mthi_write", hi, 32'hAA);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("mthi_undo_hi", hi, 32'h11);
        check("mthi_undo_lo", lo, 32'h22);

        // Flush two cycles later falls outside the window
        set_hilo(32'h11, 32'h22);
        issue(MD_MTHI, 32'hAA, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("mthi_late_flush_hi", hi, 32'hAA);

        // DIV cancelled at cycle 10, then an immediate MULTU is accepted
        set_hilo(32'h1234, 32'h5678);
        issue(MD_DIV, 32'd1000, 32'd3);
        dc = done_cnt;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("div_flush_busy", {31'd0, busy}, 32'd0);
        check("div_flush_hi", hi, 32'h1234);
        check("div_flush_lo", lo, 32'h5678);
        check("div_flush_done", {31'd0, done}, 32'd0);
        issue(MD_MULTU, 32'd3, 32'd4);
        check("after_flush_accept", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("after_flush_lo", lo, 32'd12);
        repeat (40) @(posedge clk);
        #1;
        check("after_flush_done_pulses", done_cnt - dc, 32'd1);

        // Flush beats a same-edge multiply completion
        set_hilo(32'hA1, 32'hB2);
        issue(MD_MULTU, 32'd9, 32'd9);
        dc = done_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_prio_hi", hi, 32'hA1);
        check("flush_prio_lo", lo, 32'hB2);
        check("flush_prio_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_prio_no_done", done_cnt - dc, 32'd0);

        // Start while busy is ignored
        set_hilo(32'd0, 32'd0);
        issue(MD_MULTU, 32'd6, 32'd7);
        @(negedge clk); start = 1'b1; op = MD_MULTU; src_a = 32'd100; src_b = 32'd100;
        @(posedge clk); #1; start = 1'b0;
        wait_idle(n);
        check("busy_start_latency", n + 1, 32'd5);
        check("busy_start_lo", lo, 32'd42);
        check("busy_start_hi", hi, 32'd0);

        // Start together with flush (window closed) is ignored
        set_hilo(32'h33, 32'h44);
        @(posedge clk); #1;
        @(negedge clk); start = 1'b1; flush = 1'b1; op = MD_MTHI; src_a = 32'h99;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("start_flush_hi", hi, 32'h33);
        check("start_flush_lo", lo, 32'h44);

        // Reset at cycle 3 of MULT
        set_hilo(32'h55, 32'h66);
        issue(MD_MULT, 32'd2, 32'd3);
        dc = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        check("reset_mid_hi", hi, 32'd0);
        check("reset_mid_lo", lo, 32'd0);
        check("reset_mid_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("reset_mid_no_done", done_cnt - dc, 32'd0);
        check("reset_mid_lo_after", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the MIPS pipeline; successor to the fixed-latency 32-bit unit.
- Adds configurable width, configurable multiply latency, a true iterative restoring divider (one quotient bit per cycle), MADD/MSUB accumulate ops, a done pulse, and a precise undo window for pipeline flush.
- Sits beside the EX/M stages: issue from EX, flush from exception logic, HI/LO read by MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- MUL_LAT, 5, cycles from accept to HI/LO write for MULT/MULTU/MADD*/MSUB* (legal range 1..15).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  issue strobe; accepted only when idle and flush=0.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10..15 are no-op.
- src_a  in  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data).
- src_b  in  WIDTH  rt operand.
- flush  in  1  cancel the last accepted op if it is still inside its undo window.
- busy  out  1  registered; high while a mult/div op is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO are written by a mult/div op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, undo_valid=0, FSM=IDLE. Reset mid-operation aborts the op with no HI/LO write.
- Accept condition: start & ~busy & ~flush & op<=9. At the accept edge E0, snapshot {hi,lo} into {old_hi,old_lo}, latch operands, and set undo_valid=1.
- Start while busy, or start together with flush: ignored, no state change.
- MTHI/MTLO: hi (or lo) <= src_a at E0. busy stays 0, no done pulse. undo_valid stays 1 for exactly one cycle after E0.
- Multiply ops: FSM IDLE->MUL at E0, counter loaded with MUL_LAT-1, busy=1.
  - At edge E_MUL_LAT: {hi,lo} written, busy=0, done=1 for the next cycle.
  - Signed ops sign-extend to 2*WIDTH. MADD*/MSUB* compute snapshot ± product, modulo 2^(2*WIDTH).
- Divide ops: FSM IDLE->DIV_ITER at E0.
  - Signed ops operate on magnitudes. The most-negative operand's magnitude is taken as unsigned WIDTH.
  - DIV_ITER runs WIDTH restoring iterations, one per edge E1..E_WIDTH, then moves to DIV_FIX.
  - At edge E_(WIDTH+1): sign fix (quotient negated if sign_a^sign_b, remainder takes sign of a), lo=quotient, hi=remainder, busy=0, then done.
  - Total latency WIDTH+1 edges.
- Divide by zero (src_b==0): takes the same latency, writes hi=0 and lo=0.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, from natural wrap.
- undo_valid:
  - Set at accept.
  - For MTHI/MTLO, cleared one cycle after E0.
  - For mult/div, stays set while busy and through the done cycle, then clears.
  - A new accept reloads it.
- Flush with undo_valid=1: {hi,lo} <= {old_hi,old_lo}, busy=0, done=0, FSM=IDLE, undo_valid=0, all in one edge.
- Flush with undo_valid=0: no effect.
- Flush has priority over any same-edge completion write.
- busy, done, hi and lo are all driven directly from flops; no combinational path from any input to any output.

Decomposition:
- Shared package muldiv_pkg: op encodings MD_MULT..MD_MSUBU, FSM state constants (IDLE, MUL, DIV_ITER, DIV_FIX), and an op-class helper (is_mul, is_div, is_signed, is_acc, is_sub).
- One sub-module, muldiv_div_iter: WIDTH-parametrised restoring divider core holding partial remainder, quotient shift register and iteration counter, with a start/finish handshake.
- The multiply path and HI/LO/undo control stay in the top module.

Test Plan:
- MULT with WIDTH=32, MUL_LAT=5, src_a=0xFFFFFFFD (-3), src_b=5 -> busy high 5 cycles; at E5 hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses once.
- DIVU 100/7 -> busy high 33 cycles; lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV by 0 -> hi=lo=0.
- MADDU with hi=0xFFFFFFFF, lo=0xFFFFFFFF, operands 1*1 -> wraps to hi=0, lo=0. MSUB from 0 with 2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- hi=0x11: MTHI 0xAA, flush next cycle -> hi back to 0x11. Same sequence with flush two cycles later -> hi stays 0xAA.
- DIV accepted, flush at cycle 10 -> busy=0 next cycle; hi/lo equal pre-op values; no done; a subsequent start is accepted immediately.
- Start asserted while busy with different operands -> ignored, result unchanged. Reset at cycle 3 of MULT -> hi=lo=0, busy=0, no done.
